imem_loader: RTL and testbench

- Upstream feeder for monociclo_top.
- Streams 32-bit instruction words over a valid/ready interface into the instruction memory write port.
- Holds the core in reset while loading, then releases it after a programmable hold time.
- Removes the need to preload instruction memory from a file: the bench or host pushes the program and the core starts at PC 0 on release.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams instruction words into the instruction memory write port over valid/ready,
// holding the core in reset while loading and releasing it a fixed number of cycles later.
module imem_loader #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        COMMIT = 3'd1,
        HOLD   = 3'd2,
        RUN    = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    logic              in_ready_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              core_rst_nxt;
    logic              done_nxt;
    logic              error_nxt;
    logic [CNT_W-1:0]  count_nxt;

    logic accept_c;
    logic at_top_c;

    assign accept_c = in_valid && in_ready;
    assign at_top_c = (ptr == {ADDR_W{1'b1}});

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        we_nxt    = 1'b0;
        addr_nxt  = imem_addr;
        wdata_nxt = imem_wdata;
        count_nxt = word_count;

        case (state)
            LOAD: begin
                if (accept_c) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    wdata_nxt = in_data;
                    ptr_nxt   = ptr + ADDR_W'(1);
                    count_nxt = word_count + CNT_W'(1);
                    if (in_last) begin
                        state_nxt = COMMIT;
                    end else if (at_top_c) begin
                        // Overflowing word is still written; its pulse lands on entry to ERR.
                        state_nxt = ERR;
                    end
                end
            end
            COMMIT: begin
                state_nxt = HOLD;
                hold_nxt  = HOLD_W'(HOLD_CYC - 1);
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            RUN: begin
                if (reload) begin
                    state_nxt = LOAD;
                    ptr_nxt   = '0;
                    count_nxt = '0;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase

        in_ready_nxt = (state_nxt == LOAD);
        core_rst_nxt = (state_nxt != RUN);
        done_nxt     = (state_nxt == RUN);
        error_nxt    = (state_nxt == ERR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            ptr        <= '0;
            hold_cnt   <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_nxt;
            in_ready   <= in_ready_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            core_rst   <= core_rst_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            word_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, gapped, full-depth, overflow, reload and mid-load reset.
module tb_imem_loader;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HOLD_CYC = 2;
    localparam int unsigned DEPTH    = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    imem_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         wlog[$];
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          rel_cyc = 0;
    logic        core_rst_q = 1'b1;
    logic [31:0] prog [DEPTH];

    // Write/release monitor: records every memory write and the cycle the core is released.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        core_rst_q <= core_rst;
        if (imem_we) begin
            wlog.push_back({imem_addr, imem_wdata});
            last_we_cyc <= cyc;
        end
        if (!core_rst && core_rst_q) rel_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        reload   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Offers one word after `gaps` idle cycles and waits (bounded) for the handshake.
    task automatic send(input logic [31:0] w, input logic last, input int gaps);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b0;
        repeat (gaps) step();
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            step();
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load(input int n, input logic last, input logic gapped);
        for (int i = 0; i < n; i++) begin
            send(prog[i], (i == n - 1) ? last : 1'b0, (gapped && i > 0) ? 2 : 0);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && !done; i++) step();
        check("done", 64'(done), 64'd1);
    endtask

    task automatic check_log(input string tag, input int n);
        check({tag, "_nwrites"}, 64'(wlog.size()), 64'(n));
        for (int i = 0; i < wlog.size() && i < n; i++) begin
            check({tag, "_addr"}, 64'(wlog[i].addr), 64'(i));
            check({tag, "_data"}, 64'(wlog[i].data), 64'(prog[i]));
        end
    endtask

    task automatic set_nominal();
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'hAC08_0000;
        prog[3] = 32'h8C0A_0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        reload   = 1'b0;

        // Reset values
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Nominal 4-word load, valid held high
        set_nominal();
        wlog.delete();
        load(4, 1'b1, 1'b0);
        check("nom_commit_ready", 64'(in_ready), 64'd0);
        check("nom_commit_we", 64'(imem_we), 64'd1);
        check("nom_commit_addr", 64'(imem_addr), 64'd3);
        check("nom_count", 64'(word_count), 64'd4);
        check("nom_core_held", 64'(core_rst), 64'd1);
        wait_done();
        step();
        check_log("nom", 4);
        check("nom_release_lat", 64'(rel_cyc - last_we_cyc), 64'(1 + HOLD_CYC));
        check("nom_core_run", 64'(core_rst), 64'd0);

        // in_valid ignored in RUN
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        check("run_ready", 64'(in_ready), 64'd0);
        check("run_no_write", 64'(wlog.size()), 64'd4);

        // Reload from RUN with a 2-word program
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("rl_core_rst", 64'(core_rst), 64'd1);
        check("rl_done", 64'(done), 64'd0);
        check("rl_count", 64'(word_count), 64'd0);
        check("rl_ready", 64'(in_ready), 64'd1);
        prog[0] = 32'h1111_1111;
        prog[1] = 32'h2222_2222;
        wlog.delete();
        load(2, 1'b1, 1'b0);
        wait_done();
        step();
        check_log("rl", 2);
        check("rl_count2", 64'(word_count), 64'd2);
        check("rl_release_lat", 64'(rel_cyc - last_we_cyc), 64'(1 + HOLD_CYC));

        // Gapped valid 1,0,0,1,...
        do_reset();
        set_nominal();
        wlog.delete();
        load(4, 1'b1, 1'b1);
        wait_done();
        step();
        check_log("gap", 4);
        check("gap_count", 64'(word_count), 64'd4);

        // Full depth, last on word 31
        do_reset();
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hC0DE_0000 | 32'(i * 7);
        wlog.delete();
        load(DEPTH, 1'b1, 1'b0);
        wait_done();
        step();
        check("full_error", 64'(error), 64'd0);
        check("full_count", 64'(word_count), 64'd32);
        check_log("full", DEPTH);

        // Overflow: 32 words, none flagged last
        do_reset();
        wlog.delete();
        load(DEPTH, 1'b0, 1'b0);
        check("ovf_we", 64'(imem_we), 64'd1);
        check("ovf_addr", 64'(imem_addr), 64'd31);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_core_rst", 64'(core_rst), 64'd1);
        check("ovf_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        check("ovf_we_off", 64'(imem_we), 64'd0);
        reload = 1'b1;
        step();
        reload = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        check("ovf_sticky", 64'(error), 64'd1);
        check("ovf_done", 64'(done), 64'd0);
        check_log("ovf", DEPTH);
        do_reset();
        check("ovf_cleared", 64'(error), 64'd0);

        // Reset after 2 of 4 words
        set_nominal();
        send(prog[0], 1'b0, 0);
        send(prog[1], 1'b0, 0);
        rst = 1'b1;
        step();
        check("mid_we", 64'(imem_we), 64'd0);
        check("mid_addr", 64'(imem_addr), 64'd0);
        check("mid_count", 64'(word_count), 64'd0);
        check("mid_core_rst", 64'(core_rst), 64'd1);
        check("mid_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        step();
        wlog.delete();
        load(4, 1'b1, 1'b0);
        wait_done();
        step();
        check_log("mid", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
